delayed_trigger_seq: RTL and testbench
======================================

Name: delayed_trigger_seq

Overview:
- Synchronous, programmable delayed one-shot and burst generator that sits directly downstream of the free-running clock source and the enable level `on`.
- Replaces the `#`-delay trigger behaviour with a synthesizable, cycle-counted equivalent.
- On each accepted rising edge of `on`, waits a programmed number of clock cycles, then emits a burst of equal-width high pulses on `signal`.
- Reports status (`busy`, `done`, `missed`, trigger count) to downstream logic and the testbench monitor.

Parameters:
- CW, 8, width of the `delay` and `width` count fields.
- BW, 4, width of the `burst` field (number of high pulses per trigger).
- SYNC, 0, 1 inserts a 2-flop synchronizer on `on` (adds exactly 2 cycles of latency); 0 samples `on` directly.

Ports:
- clock  input  1  system clock; all state updates on rising edge.
- reset_n  input  1  reset, asynchronous, active-low.
- on  input  1  trigger enable level; a 0->1 transition requests a trigger.
- delay  input  CW  cycles from trigger acceptance to first rising edge of `signal`; latched at acceptance.
- width  input  CW  high time and low gap of each pulse, in cycles; 0 treated as 1; latched at acceptance.
- burst  input  BW  number of high pulses; 0 treated as 1; latched at acceptance.
- signal  output  1  generated pulse train, registered.
- busy  output  1  high while state is not IDLE.
- done  output  1  one-cycle pulse when a sequence completes.
- missed  output  1  sticky; a rising edge of `on` occurred while busy.
- trig_count  output  8  number of accepted triggers, modulo 256.

Behaviour:
- Reset (async, `reset_n`=0):
  - State = IDLE; internal counters = 0.
  - `signal` = 0, `done` = 0, `missed` = 0, `trig_count` = 0, `busy` = 0.
  - The edge-history flop (and synchronizer flops) reset to 1, so `on` held high across reset release does not trigger.
- Edge detection: `rise` = `on_s` & ~`on_q`, where `on_s` is `on` (SYNC=0) or its 2-flop synchronized copy (SYNC=1).
- Timing reference: E0 is the clock edge at which `rise` is sampled while state = IDLE.
- FSM states: IDLE, DELAY, HIGH, LOW.
- IDLE:
  - On `rise`: latch `delay`/`width`/`burst`; increment `trig_count` (wraps 255->0); clear `missed`.
  - If `delay`=0: go to HIGH and set `signal`=1 at E0.
  - Otherwise: go to DELAY with cnt=`delay`.
- DELAY: each edge, if cnt=1 go to HIGH with `signal`=1 and cnt=W; else decrement cnt. `signal` therefore rises at edge E0+D.
- HIGH: each edge, if cnt=1 then `signal`=0 and one of:
  - remaining pulses > 1: go to LOW, cnt=W, decrement remaining;
  - otherwise: go to IDLE with `done`=1 for exactly one cycle.
  - Else decrement cnt. High time is exactly W cycles.
- LOW: each edge, if cnt=1 go to HIGH, `signal`=1, cnt=W; else decrement. Gap is exactly W cycles.
- Totals:
  - `signal` falls for the last time at E0+D+(2B-1)W.
  - `busy`=1 from E0 through that edge.
  - `done` is high for the cycle that follows that edge.
- Effective values: W = max(`width`,1), B = max(`burst`,1), D = `delay`.
- `rise` while busy, including on the completion edge: ignored; sequence is unaffected; `missed` set to 1 and held until the next accepted trigger.
- Input changes on `delay`/`width`/`burst` during a sequence have no effect.
- `on` falling or held high: no effect. Only rising edges count.
- Reset asserted mid-sequence: outputs go to reset values immediately (asynchronously). No `done` is produced.

Test Plan:
- Reset, then `delay`=3, `width`=2, `burst`=1, SYNC=0, raise `on` at E0 -> `signal` high on edges E3..E4 (low at E5), `done` pulse after E5, `trig_count`=1, `busy` low after E5.
- `delay`=0, `width`=0, `burst`=0 -> `signal` high for exactly 1 cycle starting at E0, `done` after E1.
- `delay`=1, `width`=3, `burst`=3 -> `signal` pattern: 3 high, 3 low, 3 high, 3 low, 3 high, starting E1, last fall at E16; exactly one `done`.
- Second `on` rise at E2 during a `delay`=5 sequence -> `signal` timing unchanged, `missed`=1 until next accepted rise clears it, `trig_count` unchanged by the ignored edge.
- Hold `on`=1 through reset release -> no trigger. Then drop and raise `on` -> accepted trigger. Repeat 256 triggers -> `trig_count` wraps to 0.
- Assert `reset_n`=0 during HIGH -> `signal`, `busy`, `done` go 0 immediately; after release, a new rise triggers normally. With SYNC=1, all timings shift by +2 cycles.

Source files
------------

// File: rtl/delayed_trigger_seq.sv
// Programmable delayed one-shot / burst generator.
// A rising edge of `on` seen while idle latches delay/width/burst. After `delay` cycles the
// block emits `burst` high pulses, each `width` cycles high, separated by `width`-cycle gaps.
// Rising edges seen while busy are dropped and recorded in the sticky `missed` flag.
module delayed_trigger_seq #(
    parameter int unsigned CW   = 8,
    parameter int unsigned BW   = 4,
    parameter int unsigned SYNC = 0
) (
    input  logic          clock,
    input  logic          reset_n,
    input  logic          on,
    input  logic [CW-1:0] delay,
    input  logic [CW-1:0] width,
    input  logic [BW-1:0] burst,
    output logic          signal,
    output logic          busy,
    output logic          done,
    output logic          missed,
    output logic [7:0]    trig_count
);

    localparam logic [1:0] StIdle  = 2'd0;
    localparam logic [1:0] StDelay = 2'd1;
    localparam logic [1:0] StHigh  = 2'd2;
    localparam logic [1:0] StLow   = 2'd3;

    logic [1:0]    state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [CW-1:0] w_q, w_d;
    logic [BW-1:0] rem_q, rem_d;
    logic          signal_q, signal_d;
    logic          done_q, done_d;
    logic          missed_q, missed_d;
    logic [7:0]    trig_q, trig_d;

    logic          on_s;
    logic          on_q;
    logic          rise;
    logic [CW-1:0] width_eff;
    logic [BW-1:0] burst_eff;

    // Optional 2-flop synchronizer; flops reset high so a level held across reset is not an edge.
    if (SYNC != 0) begin : g_sync
        logic [1:0] sync_q;

        // Shift `on` through two flops.
        always_ff @(posedge clock or negedge reset_n) begin
            if (!reset_n) begin
                sync_q <= 2'b11;
            end else begin
                sync_q <= {sync_q[0], on};
            end
        end

        assign on_s = sync_q[1];
    end else begin : g_nosync
        assign on_s = on;
    end

    // Edge history for rise detection.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            on_q <= 1'b1;
        end else begin
            on_q <= on_s;
        end
    end

    assign rise      = on_s & ~on_q;
    assign width_eff = (width == '0) ? CW'(1) : width;
    assign burst_eff = (burst == '0) ? BW'(1) : burst;

    // Sequencer next-state: counters always hold the cycles left in the current phase.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        w_d      = w_q;
        rem_d    = rem_q;
        signal_d = signal_q;
        done_d   = 1'b0;
        missed_d = missed_q;
        trig_d   = trig_q;

        unique case (state_q)
            StIdle: begin
                if (rise) begin
                    w_d      = width_eff;
                    rem_d    = burst_eff;
                    trig_d   = trig_q + 8'd1;
                    missed_d = 1'b0;
                    if (delay == '0) begin
                        state_d  = StHigh;
                        signal_d = 1'b1;
                        cnt_d    = width_eff;
                    end else begin
                        state_d = StDelay;
                        cnt_d   = delay;
                    end
                end
            end
            StDelay: begin
                if (cnt_q == CW'(1)) begin
                    state_d  = StHigh;
                    signal_d = 1'b1;
                    cnt_d    = w_q;
                end else begin
                    cnt_d = cnt_q - CW'(1);
                end
            end
            StHigh: begin
                if (cnt_q == CW'(1)) begin
                    signal_d = 1'b0;
                    if (rem_q > BW'(1)) begin
                        state_d = StLow;
                        cnt_d   = w_q;
                        rem_d   = rem_q - BW'(1);
                    end else begin
                        state_d = StIdle;
                        cnt_d   = '0;
                        done_d  = 1'b1;
                    end
                end else begin
                    cnt_d = cnt_q - CW'(1);
                end
            end
            StLow: begin
                if (cnt_q == CW'(1)) begin
                    state_d  = StHigh;
                    signal_d = 1'b1;
                    cnt_d    = w_q;
                end else begin
                    cnt_d = cnt_q - CW'(1);
                end
            end
            default: begin
                state_d  = StIdle;
                signal_d = 1'b0;
                cnt_d    = '0;
            end
        endcase

        // Edges arriving while busy (including the completion edge) are dropped but remembered.
        if (rise && (state_q != StIdle)) begin
            missed_d = 1'b1;
        end
    end

    // Sequencer state registers.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= StIdle;
            cnt_q    <= '0;
            w_q      <= '0;
            rem_q    <= '0;
            signal_q <= 1'b0;
            done_q   <= 1'b0;
            missed_q <= 1'b0;
            trig_q   <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            w_q      <= w_d;
            rem_q    <= rem_d;
            signal_q <= signal_d;
            done_q   <= done_d;
            missed_q <= missed_d;
            trig_q   <= trig_d;
        end
    end

    assign signal     = signal_q;
    assign busy       = (state_q != StIdle);
    assign done       = done_q;
    assign missed     = missed_q;
    assign trig_count = trig_q;

endmodule

// File: tb/tb_delayed_trigger_seq.sv
// Scoreboard bench: two DUTs (SYNC=0 and SYNC=1) share stimulus; each accepted trigger pushes
// the expected pulse-train summary per instance, and a per-instance monitor pops it on `done`.
module tb_delayed_trigger_seq;

    typedef struct {
        int         first_hi;
        int         last_hi;
        int         n_rise;
        int         hi_cyc;
        int         busy_cyc;
        int         done_cyc;
        logic [7:0] trig;
        logic       missed;
    } exp_t;

    logic       clock;
    logic       reset_n;
    logic       on_i;
    logic [7:0] delay_i;
    logic [7:0] width_i;
    logic [3:0] burst_i;

    logic       sig_w  [2];
    logic       busy_w [2];
    logic       done_w [2];
    logic       miss_w [2];
    logic [7:0] trig_w [2];

    exp_t       q0[$];
    exp_t       q1[$];
    int         total = 0;
    int         bad   = 0;
    int         cyc   = 0;
    logic [7:0] exp_trig = 8'd0;

    delayed_trigger_seq #(.CW(8), .BW(4), .SYNC(0)) u_dut0 (
        .clock      (clock),
        .reset_n    (reset_n),
        .on         (on_i),
        .delay      (delay_i),
        .width      (width_i),
        .burst      (burst_i),
        .signal     (sig_w[0]),
        .busy       (busy_w[0]),
        .done       (done_w[0]),
        .missed     (miss_w[0]),
        .trig_count (trig_w[0])
    );

    delayed_trigger_seq #(.CW(8), .BW(4), .SYNC(1)) u_dut1 (
        .clock      (clock),
        .reset_n    (reset_n),
        .on         (on_i),
        .delay      (delay_i),
        .width      (width_i),
        .burst      (burst_i),
        .signal     (sig_w[1]),
        .busy       (busy_w[1]),
        .done       (done_w[1]),
        .missed     (miss_w[1]),
        .trig_count (trig_w[1])
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    // Posedge counter: after posedge number n, cyc == n until the next posedge.
    initial begin
        forever begin
            @(posedge clock);
            cyc = cyc + 1;
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got no finish, want finish before time limit");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input int inst, input int act, input int exp);
        total = total + 1;
        if (act != exp) begin
            bad = bad + 1;
            $display("FAIL %s inst%0d: got %0d, want %0d", name, inst, act, exp);
        end
    endtask

    // Expected summary from the closed-form timing: last fall at E0+D+(2B-1)W.
    function automatic void push_exp(input int e0, input int d, input int w, input int b,
                                     input logic [7:0] t, input logic m);
        exp_t e;
        int   we;
        int   be;
        int   last;
        we         = (w == 0) ? 1 : w;
        be         = (b == 0) ? 1 : b;
        last       = e0 + d + (2 * be - 1) * we;
        e.first_hi = e0 + d;
        e.last_hi  = last - 1;
        e.n_rise   = be;
        e.hi_cyc   = be * we;
        e.busy_cyc = last - e0;
        e.done_cyc = last;
        e.trig     = t;
        e.missed   = m;
        q0.push_back(e);
        e.first_hi = e.first_hi + 2;
        e.last_hi  = e.last_hi + 2;
        e.done_cyc = e.done_cyc + 2;
        q1.push_back(e);
    endfunction

    for (genvar g = 0; g < 2; g++) begin : g_mon
        int   first_hi;
        int   last_hi;
        int   n_rise;
        int   hi_cyc;
        int   busy_cyc;
        logic seen;
        logic prev_sig;
        logic prev_done;
        logic have;
        exp_t e;

        initial begin
            forever begin
                @(negedge clock);
                if (!reset_n) begin
                    first_hi  = -1;
                    last_hi   = -1;
                    n_rise    = 0;
                    hi_cyc    = 0;
                    busy_cyc  = 0;
                    seen      = 1'b0;
                    prev_sig  = 1'b0;
                    prev_done = 1'b0;
                end else begin
                    if (prev_done) begin
                        chk("done_width", g, int'(done_w[g]), 0);
                    end
                    if (busy_w[g]) begin
                        busy_cyc = busy_cyc + 1;
                    end
                    if (sig_w[g]) begin
                        hi_cyc  = hi_cyc + 1;
                        last_hi = cyc;
                        if (!prev_sig) begin
                            n_rise = n_rise + 1;
                            if (!seen) begin
                                first_hi = cyc;
                                seen     = 1'b1;
                            end
                        end
                    end
                    if (done_w[g]) begin
                        have = 1'b0;
                        if (g == 0) begin
                            if (q0.size() > 0) begin
                                e    = q0.pop_front();
                                have = 1'b1;
                            end
                        end else begin
                            if (q1.size() > 0) begin
                                e    = q1.pop_front();
                                have = 1'b1;
                            end
                        end
                        if (!have) begin
                            total = total + 1;
                            bad   = bad + 1;
                            $display("FAIL unexpected_done inst%0d: got done at %0d, want none",
                                     g, cyc);
                        end else begin
                            chk("first_hi", g, first_hi, e.first_hi);
                            chk("last_hi", g, last_hi, e.last_hi);
                            chk("pulses", g, n_rise, e.n_rise);
                            chk("hi_cycles", g, hi_cyc, e.hi_cyc);
                            chk("busy_cycles", g, busy_cyc, e.busy_cyc);
                            chk("done_cyc", g, cyc, e.done_cyc);
                            chk("trig_count", g, int'(trig_w[g]), int'(e.trig));
                            chk("missed", g, int'(miss_w[g]), int'(e.missed));
                        end
                        first_hi = -1;
                        last_hi  = -1;
                        n_rise   = 0;
                        hi_cyc   = 0;
                        busy_cyc = 0;
                        seen     = 1'b0;
                    end
                    prev_sig  = sig_w[g];
                    prev_done = done_w[g];
                end
            end
        end
    end

    task automatic scramble();
        delay_i = 8'hAA;
        width_i = 8'h55;
        burst_i = 4'hF;
    endtask

    // One trigger; inputs held until the synchronized instance has also latched them.
    task automatic trig_seq(input int d, input int w, input int b);
        @(negedge clock);
        delay_i  = 8'(d);
        width_i  = 8'(w);
        burst_i  = 4'(b);
        on_i     = 1'b1;
        exp_trig = exp_trig + 8'd1;
        push_exp(cyc + 1, d, w, b, exp_trig, 1'b0);
        repeat (4) @(negedge clock);
        on_i = 1'b0;
        scramble();
    endtask

    task automatic wait_done(input int bound);
        int n;
        n = 0;
        while ((q0.size() != 0 || q1.size() != 0) && n < bound) begin
            @(negedge clock);
            n = n + 1;
        end
        if (q0.size() != 0 || q1.size() != 0) begin
            total = total + 1;
            bad   = bad + 1;
            $display("FAIL timeout: got %0d/%0d pending, want 0/0", q0.size(), q1.size());
            q0.delete();
            q1.delete();
        end
        repeat (2) @(negedge clock);
    endtask

    task automatic pulse_reset();
        #2 reset_n = 1'b0;
        @(negedge clock);
        #2 reset_n = 1'b1;
        exp_trig = 8'd0;
    endtask

    initial begin
        reset_n = 1'b0;
        on_i    = 1'b0;
        delay_i = 8'd0;
        width_i = 8'd0;
        burst_i = 4'd0;
        repeat (2) @(negedge clock);
        for (int i = 0; i < 2; i++) begin
            chk("rst_signal", i, int'(sig_w[i]), 0);
            chk("rst_busy", i, int'(busy_w[i]), 0);
            chk("rst_done", i, int'(done_w[i]), 0);
            chk("rst_missed", i, int'(miss_w[i]), 0);
            chk("rst_trig", i, int'(trig_w[i]), 0);
        end
        #2 reset_n = 1'b1;

        trig_seq(3, 2, 1);
        wait_done(40);
        trig_seq(0, 0, 0);
        wait_done(40);
        trig_seq(1, 3, 3);
        wait_done(60);

        // Second rise at E2 during a delay=5 sequence is dropped.
        @(negedge clock);
        delay_i  = 8'd5;
        width_i  = 8'd1;
        burst_i  = 4'd2;
        on_i     = 1'b1;
        exp_trig = exp_trig + 8'd1;
        push_exp(cyc + 1, 5, 1, 2, exp_trig, 1'b1);
        @(negedge clock);
        on_i = 1'b0;
        @(negedge clock);
        on_i = 1'b1;
        repeat (3) @(negedge clock);
        on_i = 1'b0;
        scramble();
        wait_done(40);
        for (int i = 0; i < 2; i++) begin
            chk("missed_held", i, int'(miss_w[i]), 1);
        end
        trig_seq(2, 1, 1);
        wait_done(40);
        for (int i = 0; i < 2; i++) begin
            chk("missed_cleared", i, int'(miss_w[i]), 0);
        end

        // `on` high across reset release must not trigger.
        @(negedge clock);
        on_i = 1'b1;
        pulse_reset();
        repeat (6) @(negedge clock);
        for (int i = 0; i < 2; i++) begin
            chk("hold_busy", i, int'(busy_w[i]), 0);
            chk("hold_trig", i, int'(trig_w[i]), 0);
        end
        on_i = 1'b0;
        repeat (3) @(negedge clock);
        trig_seq(1, 1, 1);
        wait_done(40);

        // 256 back-to-back minimal triggers wrap the counter to 0.
        @(negedge clock);
        pulse_reset();
        for (int i = 0; i < 256; i++) begin
            @(negedge clock);
            delay_i  = 8'd0;
            width_i  = 8'd1;
            burst_i  = 4'd1;
            on_i     = 1'b1;
            exp_trig = exp_trig + 8'd1;
            push_exp(cyc + 1, 0, 1, 1, exp_trig, 1'b0);
            @(negedge clock);
            on_i = 1'b0;
            @(negedge clock);
        end
        wait_done(40);
        for (int i = 0; i < 2; i++) begin
            chk("wrap_trig", i, int'(trig_w[i]), 0);
        end

        // Reset during HIGH aborts without done.
        @(negedge clock);
        delay_i  = 8'd2;
        width_i  = 8'd6;
        burst_i  = 4'd1;
        on_i     = 1'b1;
        exp_trig = exp_trig + 8'd1;
        push_exp(cyc + 1, 2, 6, 1, exp_trig, 1'b0);
        repeat (5) @(negedge clock);
        on_i = 1'b0;
        for (int i = 0; i < 2; i++) begin
            chk("pre_abort_signal", i, int'(sig_w[i]), 1);
        end
        #2 reset_n = 1'b0;
        #1;
        for (int i = 0; i < 2; i++) begin
            chk("abort_signal", i, int'(sig_w[i]), 0);
            chk("abort_busy", i, int'(busy_w[i]), 0);
            chk("abort_done", i, int'(done_w[i]), 0);
        end
        q0.delete();
        q1.delete();
        @(negedge clock);
        #2 reset_n = 1'b1;
        exp_trig = 8'd0;
        trig_seq(3, 2, 1);
        wait_done(40);

        repeat (4) @(negedge clock);
        chk("queue_left", 0, q0.size(), 0);
        chk("queue_left", 1, q1.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
